// File: rtl/collision_score.sv
// collision_score: per-frame hit/score evaluator for the bird game.
// Each accepted frame snapshots bird and pipe positions, checks the ground and
// three pipes one per cycle, then sets the sticky dead flag or bumps the BCD score.
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   new_frame                   one-cycle pulse per video frame
//   game_start, game_fly        game FSM state levels (START / FLY)
//   bird_pos_x/y, pipeN_pos_x/y signed 16-bit positions (x vertical, y scroll)
//   dead                        sticky hit flag
//   score_bcd, best_bcd         3-digit BCD score and best score
//   score_pulse                 one-cycle pulse per score increment
//   busy                        high while a frame evaluation is in progress
module collision_score #(
    parameter int BIRD_W   = 34,
    parameter int BIRD_H   = 24,
    parameter int PIPE_W   = 52,
    parameter int GAP      = 100,
    parameter int GROUND_X = 104,
    parameter int SPEED    = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               new_frame,
    input  logic               game_start,
    input  logic               game_fly,
    input  logic signed [15:0] bird_pos_x,
    input  logic signed [15:0] bird_pos_y,
    input  logic signed [15:0] pipe1_pos_x,
    input  logic signed [15:0] pipe1_pos_y,
    input  logic signed [15:0] pipe2_pos_x,
    input  logic signed [15:0] pipe2_pos_y,
    input  logic signed [15:0] pipe3_pos_x,
    input  logic signed [15:0] pipe3_pos_y,
    output logic               dead,
    output logic [11:0]        score_bcd,
    output logic [11:0]        best_bcd,
    output logic               score_pulse,
    output logic               busy
);

    localparam int unsigned POS_W = 16;
    localparam int unsigned EXT_W = 18;

    // Constants pre-folded so every compare is a plain signed 18-bit compare.
    localparam logic signed [EXT_W-1:0] K_BIRD_W1 = EXT_W'(BIRD_W - 1);
    localparam logic signed [EXT_W-1:0] K_BIRD_H1 = EXT_W'(BIRD_H - 1);
    localparam logic signed [EXT_W-1:0] K_PIPE_W1 = EXT_W'(PIPE_W - 1);
    localparam logic signed [EXT_W-1:0] K_PIPE_W  = EXT_W'(PIPE_W);
    localparam logic signed [EXT_W-1:0] K_GAP1    = EXT_W'(GAP - 1);
    localparam logic signed [EXT_W-1:0] K_GROUND  = EXT_W'(GROUND_X);
    localparam logic signed [EXT_W-1:0] K_SPEED   = EXT_W'(SPEED);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNAP   = 3'd1,
        ST_CHK_G  = 3'd2,
        ST_CHK_P1 = 3'd3,
        ST_CHK_P2 = 3'd4,
        ST_CHK_P3 = 3'd5,
        ST_UPDATE = 3'd6
    } state_e;

    state_e                   state_q;
    logic                     dead_q;
    logic [11:0]              score_q;
    logic [11:0]              best_q;
    logic                     pulse_q;
    logic                     busy_q;
    logic                     hit_acc_q;
    logic                     pass_acc_q;
    logic signed [POS_W-1:0]  bx_q, by_q;
    logic signed [POS_W-1:0]  p1x_q, p1y_q, p2x_q, p2y_q, p3x_q, p3y_q;

    logic signed [EXT_W-1:0]  bx, by, px, py;
    logic                     gnd_hit, y_ovl, pipe_hit, pipe_pass;
    logic [11:0]              score_inc;

    // Next BCD value with per-digit carry; caller guarantees value < 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    // Pipe under test is selected by the current check state.
    always_comb begin
        bx = EXT_W'(bx_q);
        by = EXT_W'(by_q);
        px = EXT_W'(p1x_q);
        py = EXT_W'(p1y_q);
        case (state_q)
            ST_CHK_P2: begin
                px = EXT_W'(p2x_q);
                py = EXT_W'(p2y_q);
            end
            ST_CHK_P3: begin
                px = EXT_W'(p3x_q);
                py = EXT_W'(p3y_q);
            end
            default: ;
        endcase
    end

    assign gnd_hit   = (bx <= K_GROUND);
    assign y_ovl     = (py <= by + K_BIRD_W1) && (py + K_PIPE_W1 >= by);
    assign pipe_hit  = y_ovl && ((bx < px) || (bx + K_BIRD_H1 > px + K_GAP1));
    // Trailing edge crossed the bird's left edge during this frame's scroll.
    assign pipe_pass = (by - K_SPEED < py + K_PIPE_W) && (py + K_PIPE_W <= by);
    assign score_inc = bcd_inc(score_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            dead_q     <= 1'b0;
            score_q    <= 12'h000;
            best_q     <= 12'h000;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            hit_acc_q  <= 1'b0;
            pass_acc_q <= 1'b0;
            bx_q       <= '0;
            by_q       <= '0;
            p1x_q      <= '0;
            p1y_q      <= '0;
            p2x_q      <= '0;
            p2y_q      <= '0;
            p3x_q      <= '0;
            p3y_q      <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (new_frame) begin
                        if (game_start) begin
                            dead_q  <= 1'b0;
                            score_q <= 12'h000;
                        end else if (game_fly && !dead_q) begin
                            state_q    <= ST_SNAP;
                            busy_q     <= 1'b1;
                            hit_acc_q  <= 1'b0;
                            pass_acc_q <= 1'b0;
                        end
                    end
                end
                ST_SNAP: begin
                    bx_q    <= bird_pos_x;
                    by_q    <= bird_pos_y;
                    p1x_q   <= pipe1_pos_x;
                    p1y_q   <= pipe1_pos_y;
                    p2x_q   <= pipe2_pos_x;
                    p2y_q   <= pipe2_pos_y;
                    p3x_q   <= pipe3_pos_x;
                    p3y_q   <= pipe3_pos_y;
                    state_q <= ST_CHK_G;
                end
                ST_CHK_G: begin
                    hit_acc_q <= hit_acc_q | gnd_hit;
                    state_q   <= ST_CHK_P1;
                end
                ST_CHK_P1, ST_CHK_P2, ST_CHK_P3: begin
                    hit_acc_q  <= hit_acc_q | pipe_hit;
                    pass_acc_q <= pass_acc_q | pipe_pass;
                    state_q    <= (state_q == ST_CHK_P1) ? ST_CHK_P2 :
                                  (state_q == ST_CHK_P2) ? ST_CHK_P3 : ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (hit_acc_q) begin
                        dead_q <= 1'b1;
                        if (score_q > best_q) begin
                            best_q <= score_q;
                        end
                    end else if (pass_acc_q && (score_q != 12'h999)) begin
                        score_q <= score_inc;
                        pulse_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dead        = dead_q;
    assign score_bcd   = score_q;
    assign best_bcd    = best_q;
    assign score_pulse = pulse_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_collision_score.sv
module tb_collision_score;

    logic               clk = 1'b0;
    logic               rstn;
    logic               new_frame;
    logic               game_start;
    logic               game_fly;
    logic signed [15:0] bird_pos_x, bird_pos_y;
    logic signed [15:0] pipe1_pos_x, pipe1_pos_y;
    logic signed [15:0] pipe2_pos_x, pipe2_pos_y;
    logic signed [15:0] pipe3_pos_x, pipe3_pos_y;
    logic               dead;
    logic [11:0]        score_bcd;
    logic [11:0]        best_bcd;
    logic               score_pulse;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int pulses0;

    collision_score dut (
        .clk         (clk),
        .rstn        (rstn),
        .new_frame   (new_frame),
        .game_start  (game_start),
        .game_fly    (game_fly),
        .bird_pos_x  (bird_pos_x),
        .bird_pos_y  (bird_pos_y),
        .pipe1_pos_x (pipe1_pos_x),
        .pipe1_pos_y (pipe1_pos_y),
        .pipe2_pos_x (pipe2_pos_x),
        .pipe2_pos_y (pipe2_pos_y),
        .pipe3_pos_x (pipe3_pos_x),
        .pipe3_pos_y (pipe3_pos_y),
        .dead        (dead),
        .score_bcd   (score_bcd),
        .best_bcd    (best_bcd),
        .score_pulse (score_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (score_pulse === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse new_frame; returns just after the accepting posedge.
    task automatic pulse(input logic start, input logic fly);
        @(negedge clk);
        new_frame  = 1'b1;
        game_start = start;
        game_fly   = fly;
        @(negedge clk);
        new_frame  = 1'b0;
        game_start = 1'b0;
        game_fly   = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fly_frame();
        pulse(1'b0, 1'b1);
        wait_cyc(7);
    endtask

    task automatic start_frame();
        pulse(1'b1, 1'b0);
        wait_cyc(2);
    endtask

    task automatic set_pos(input int bx, input int by,
                           input int p1x, input int p1y,
                           input int p2x, input int p2y,
                           input int p3x, input int p3y);
        bird_pos_x  = 16'(bx);
        bird_pos_y  = 16'(by);
        pipe1_pos_x = 16'(p1x);
        pipe1_pos_y = 16'(p1y);
        pipe2_pos_x = 16'(p2x);
        pipe2_pos_y = 16'(p2y);
        pipe3_pos_x = 16'(p3x);
        pipe3_pos_y = 16'(p3y);
    endtask

    initial begin
        rstn       = 1'b0;
        new_frame  = 1'b0;
        game_start = 1'b0;
        game_fly   = 1'b1;
        set_pos(300, 100, 280, 600, 280, 600, 280, 600);
        wait_cyc(3);
        check("rst_dead",  16'(dead),        16'h0);
        check("rst_score", 16'(score_bcd),   16'h000);
        check("rst_best",  16'(best_bcd),    16'h000);
        check("rst_pulse", 16'(score_pulse), 16'h0);
        check("rst_busy",  16'(busy),        16'h0);
        rstn = 1'b1;
        wait_cyc(2);

        // Ground hit with latency checks
        set_pos(104, 100, 280, 600, 280, 600, 280, 600);
        pulse(1'b0, 1'b1);
        check("gnd_busy_on", 16'(busy), 16'h1);
        wait_cyc(5);
        check("gnd_dead_early", 16'(dead), 16'h0);
        check("gnd_busy_mid",   16'(busy), 16'h1);
        wait_cyc(1);
        check("gnd_dead",     16'(dead),      16'h1);
        check("gnd_busy_off", 16'(busy),      16'h0);
        check("gnd_score",    16'(score_bcd), 16'h000);
        wait_cyc(2);
        // Dead bird: fly frames are not evaluated
        pulse(1'b0, 1'b1);
        check("dead_no_eval", 16'(busy), 16'h0);
        wait_cyc(7);
        start_frame();
        check("start_dead",  16'(dead),      16'h0);
        check("start_score", 16'(score_bcd), 16'h000);

        // Clean pass through gap
        set_pos(300, 100, 280, 100, 280, 600, 280, 600);
        fly_frame();
        check("gap_dead",  16'(dead),      16'h0);
        check("gap_score", 16'(score_bcd), 16'h000);

        // Bird top above gap top
        set_pos(370, 100, 280, 90, 280, 600, 280, 600);
        fly_frame();
        check("pipe_hit_top", 16'(dead), 16'h1);
        start_frame();

        // Bird below gap on pipe 3
        set_pos(200, 100, 280, 600, 280, 600, 280, 120);
        fly_frame();
        check("pipe3_hit_low", 16'(dead), 16'h1);
        start_frame();

        // Seven passes then a hit -> best = 007
        set_pos(300, 100, 280, 46, 280, 600, 280, 600);
        pulses0 = pulses;
        for (int i = 0; i < 7; i++) fly_frame();
        check("score7",   16'(score_bcd),    16'h007);
        check("pulses7",  16'(pulses - pulses0), 16'd7);
        set_pos(104, 100, 280, 46, 280, 600, 280, 600);
        fly_frame();
        check("best7_dead",  16'(dead),      16'h1);
        check("best7_best",  16'(best_bcd),  16'h007);
        check("best7_score", 16'(score_bcd), 16'h007);
        start_frame();
        check("best7_clr_score", 16'(score_bcd), 16'h000);
        check("best7_keep_best", 16'(best_bcd),  16'h007);

        // Two pipes pass in one frame -> one increment
        set_pos(300, 100, 280, 46, 280, 47, 280, 600);
        pulses0 = pulses;
        fly_frame();
        check("multi_score",  16'(score_bcd),        16'h001);
        check("multi_pulses", 16'(pulses - pulses0), 16'd1);

        // Pass on pipe 1 and hit on pipe 2 in one frame
        set_pos(370, 100, 280, 46, 280, 90, 280, 600);
        pulses0 = pulses;
        fly_frame();
        check("hitpass_dead",   16'(dead),               16'h1);
        check("hitpass_score",  16'(score_bcd),          16'h001);
        check("hitpass_pulses", 16'(pulses - pulses0),   16'd0);
        check("hitpass_best",   16'(best_bcd),           16'h007);
        start_frame();

        // Digit carry 009 -> 010, then best = 012
        set_pos(300, 100, 280, 46, 280, 600, 280, 600);
        for (int i = 0; i < 9; i++) fly_frame();
        check("score9", 16'(score_bcd), 16'h009);
        pulses0 = pulses;
        fly_frame();
        check("score10",      16'(score_bcd),        16'h010);
        check("score10_pulse", 16'(pulses - pulses0), 16'd1);
        fly_frame();
        fly_frame();
        check("score12", 16'(score_bcd), 16'h012);
        set_pos(104, 100, 280, 600, 280, 600, 280, 600);
        fly_frame();
        check("best12",      16'(best_bcd), 16'h012);
        check("best12_dead", 16'(dead),     16'h1);
        start_frame();
        check("b12_clr_score", 16'(score_bcd), 16'h000);
        check("b12_clr_dead",  16'(dead),      16'h0);
        check("b12_keep_best", 16'(best_bcd),  16'h012);

        // Saturation at 999
        set_pos(300, 100, 280, 46, 280, 600, 280, 600);
        for (int i = 0; i < 99; i++) fly_frame();
        check("score99", 16'(score_bcd), 16'h099);
        fly_frame();
        check("score100", 16'(score_bcd), 16'h100);
        for (int i = 0; i < 899; i++) fly_frame();
        check("score999", 16'(score_bcd), 16'h999);
        pulses0 = pulses;
        fly_frame();
        check("sat_score", 16'(score_bcd),        16'h999);
        check("sat_pulse", 16'(pulses - pulses0), 16'd0);
        check("sat_dead",  16'(dead),             16'h0);
        start_frame();

        // new_frame while busy is ignored
        pulses0 = pulses;
        pulse(1'b0, 1'b1);
        wait_cyc(1);
        pulse(1'b0, 1'b1);
        wait_cyc(3);
        check("ign_busy_end", 16'(busy), 16'h0);
        wait_cyc(8);
        check("ign_score",  16'(score_bcd),        16'h001);
        check("ign_pulses", 16'(pulses - pulses0), 16'd1);
        check("ign_busy",   16'(busy),             16'h0);

        // Reset during CHK_P2
        set_pos(104, 100, 280, 600, 280, 600, 280, 600);
        pulse(1'b0, 1'b1);
        wait_cyc(3);
        rstn = 1'b0;
        #1;
        check("mrst_dead",  16'(dead),        16'h0);
        check("mrst_score", 16'(score_bcd),   16'h000);
        check("mrst_best",  16'(best_bcd),    16'h000);
        check("mrst_pulse", 16'(score_pulse), 16'h0);
        check("mrst_busy",  16'(busy),        16'h0);
        wait_cyc(2);
        rstn = 1'b1;
        wait_cyc(6);
        check("mrst_idle_busy", 16'(busy), 16'h0);
        check("mrst_idle_dead", 16'(dead), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
